// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the execute-stage branch resolution slice.
//   ADDR_W     : default instruction address width
//   PC_INC     : byte distance to the fall-through instruction
//   bq_entry_t : one in-flight branch record {pc, predict}
//   br_state_t : control FSM states (RUN, FLUSH)
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam int ADDR_W = 32;
  localparam int PC_INC = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              predict;
  } bq_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/bq_fifo.sv
// ---------------------------------------------------------------------------
// bq_fifo
// Synchronous FIFO that holds in-flight branch records in program order.
// Pointers carry one extra wrap bit so that full and empty are told apart
// without an occupancy counter.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : synchronous flush of every entry (priority over push/pop)
//   push, din  : write one entry (ignored while full)
//   pop        : retire the head entry (ignored while empty)
//   head       : oldest entry, valid while empty is 0
//   full/empty : occupancy flags, derived from registered pointers only
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module bq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(branch_pkg::bq_entry_t)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  import branch_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same slot index with opposite wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer update; clear discards everything including a same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
// Execute-stage branch resolution. Fetch pushes every predicted branch into
// an in-order queue; when execute resolves the oldest branch its outcome is
// compared with the stored prediction, the predictor is trained one cycle
// later, and a mispredict raises a one-cycle flush carrying the recovery PC.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   f_valid/f_pc/f_predict  : fetch push of one predicted branch
//   f_ready                 : push accepted this cycle (registered state only)
//   r_valid/r_taken/r_target: execute resolves the oldest in-flight branch
//   flush/redirect_pc       : mispredict pulse and recovery fetch address
//   upd_valid/addr/taken    : predictor training strobe, address and outcome
//   empty                   : no branches in flight
//   branch_cnt/mispred_cnt  : saturating resolution / mispredict counters
// ---------------------------------------------------------------------------
module branch_resolve #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = branch_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              f_predict,
  output logic              f_ready,
  input  logic              r_valid,
  input  logic              r_taken,
  input  logic [ADDR_W-1:0] r_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic              upd_taken,
  output logic              empty,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  import branch_pkg::*;

  // Queue entries are packed as {pc, predict}, matching bq_entry_t layout.
  localparam int EW = ADDR_W + 1;

  br_state_t         state_q;
  br_state_t         state_d;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head_data;
  logic [ADDR_W-1:0] head_pc;
  logic              head_predict;
  logic              q_full;
  logic              q_empty;
  logic              resolve;
  logic              mis;
  logic              push;
  logic              clear;

  assign push_data    = {f_pc, f_predict};
  assign head_pc      = head_data[EW-1:1];
  assign head_predict = head_data[0];

  // The FLUSH state is the flush pulse itself, so flush is registered.
  assign flush   = (state_q == FLUSH);
  assign f_ready = !q_full && !flush;
  assign empty   = q_empty;

  bq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (push_data),
    .pop   (resolve),
    .head  (head_data),
    .full  (q_full),
    .empty (q_empty)
  );

  // Control FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and queue control. In FLUSH execute is being squashed, so a
  // resolve is ignored; pushes are already blocked through f_ready. A push
  // that coincides with a mispredict is wrong-path and is dropped.
  always_comb begin
    state_d = state_q;
    resolve = 1'b0;
    mis     = 1'b0;
    push    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      RUN: begin
        resolve = r_valid && !q_empty;
        mis     = resolve && (r_taken ^ head_predict);
        clear   = mis;
        push    = f_valid && f_ready && !mis;
        if (mis) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Predictor update and recovery PC registers. Address/outcome hold their
  // last value between strobes; consumers qualify them with upd_valid/flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_addr    <= '0;
      upd_taken   <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_valid <= resolve;
      if (resolve) begin
        upd_addr  <= head_pc;
        upd_taken <= r_taken;
      end
      if (mis) begin
        redirect_pc <= r_taken ? r_target : head_pc + ADDR_W'(PC_INC);
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && (branch_cnt != {CNT_W{1'b1}})) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mis && (mispred_cnt != {CNT_W{1'b1}})) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
// Self-checking bench for branch_resolve. A reference model of the in-flight
// queue, FSM and counters computes the expected outputs for every driven
// cycle; each record is queued when stimulus is applied and popped for
// comparison once the DUT has clocked it.
// ---------------------------------------------------------------------------
module tb_branch_resolve;
  import branch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_predict;
  logic        f_ready;
  logic        r_valid;
  logic        r_taken;
  logic [31:0] r_target;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic        upd_taken;
  logic        empty;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  typedef struct {
    logic        uv;
    logic [31:0] ua;
    logic        ut;
    logic        fl;
    logic [31:0] rp;
    logic        em;
    logic        fr;
    logic [15:0] bc;
    logic [15:0] mc;
  } exp_t;

  exp_t      exp_q[$];
  bq_entry_t mq[$];
  logic      m_flush;
  logic [15:0] m_bc;
  logic [15:0] m_mc;
  int        n_cmp;
  int        n_bad;

  branch_resolve #(
    .DEPTH  (DEPTH),
    .ADDR_W (32),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_valid     (f_valid),
    .f_pc        (f_pc),
    .f_predict   (f_predict),
    .f_ready     (f_ready),
    .r_valid     (r_valid),
    .r_taken     (r_taken),
    .r_target    (r_target),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_addr    (upd_addr),
    .upd_taken   (upd_taken),
    .empty       (empty),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the reference model, queue the
  // expected post-edge outputs, then step past the edge.
  task automatic cycle(input logic fv, input logic [31:0] fpc, input logic fp,
                       input logic rv, input logic rt, input logic [31:0] rtg);
    exp_t      e;
    bq_entry_t h;
    bq_entry_t n;
    logic      res;
    logic      mis;
    logic      fr_now;
    logic      psh;
    f_valid   = fv;
    f_pc      = fpc;
    f_predict = fp;
    r_valid   = rv;
    r_taken   = rt;
    r_target  = rtg;
    fr_now = (mq.size() < DEPTH) && !m_flush;
    res    = rv && (mq.size() > 0) && !m_flush;
    mis    = 1'b0;
    h      = '0;
    e.uv = res; e.ua = 32'h0; e.ut = 1'b0; e.rp = 32'h0;
    if (res) begin
      h = mq[0];
      mis = rt ^ h.predict;
      e.ua = h.pc;
      e.ut = rt;
      if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
    end
    psh = fv && fr_now && !mis;
    if (mis) begin
      e.rp = rt ? rtg : h.pc + 32'(PC_INC);
      if (m_mc != 16'hFFFF) m_mc = m_mc + 16'd1;
      mq.delete();
    end else begin
      if (res) void'(mq.pop_front());
      if (psh) begin
        n.pc = fpc;
        n.predict = fp;
        mq.push_back(n);
      end
    end
    m_flush = mis;
    e.fl = mis;
    e.em = (mq.size() == 0);
    e.fr = (mq.size() < DEPTH) && !m_flush;
    e.bc = m_bc;
    e.mc = m_mc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Reset and compare every output with its reset value.
  task automatic test_reset(input string tag);
    rst_n = 1'b0;
    f_valid = 1'b0; r_valid = 1'b0; f_pc = 32'h0; f_predict = 1'b0;
    r_taken = 1'b0; r_target = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete(); exp_q.delete();
    m_flush = 1'b0; m_bc = 16'h0; m_mc = 16'h0;
    n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("[TB] FAIL %s.flush got %0b want 0", tag, flush); end
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL %s.upd_valid got %0b want 0", tag, upd_valid); end
    n_cmp++; if (upd_taken !== 1'b0) begin n_bad++; $display("[TB] FAIL %s.upd_taken got %0b want 0", tag, upd_taken); end
    n_cmp++; if (upd_addr !== 32'h0) begin n_bad++; $display("[TB] FAIL %s.upd_addr got %h want 0", tag, upd_addr); end
    n_cmp++; if (redirect_pc !== 32'h0) begin n_bad++; $display("[TB] FAIL %s.redirect_pc got %h want 0", tag, redirect_pc); end
    n_cmp++; if (branch_cnt !== 16'h0) begin n_bad++; $display("[TB] FAIL %s.branch_cnt got %h want 0", tag, branch_cnt); end
    n_cmp++; if (mispred_cnt !== 16'h0) begin n_bad++; $display("[TB] FAIL %s.mispred_cnt got %h want 0", tag, mispred_cnt); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("[TB] FAIL %s.empty got %0b want 1", tag, empty); end
    n_cmp++; if (f_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL %s.f_ready got %0b want 1", tag, f_ready); end
  endtask

  task automatic test_correct_predict();
    exp_t e;
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (empty !== e.em) begin n_bad++; $display("[TB] FAIL correct.empty_after_push got %0b want %0b", empty, e.em); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h200);
    e = exp_q.pop_front();
    n_cmp++; if (upd_valid !== e.uv) begin n_bad++; $display("[TB] FAIL correct.upd_valid got %0b want %0b", upd_valid, e.uv); end
    n_cmp++; if (upd_addr !== e.ua) begin n_bad++; $display("[TB] FAIL correct.upd_addr got %h want %h", upd_addr, e.ua); end
    n_cmp++; if (upd_taken !== e.ut) begin n_bad++; $display("[TB] FAIL correct.upd_taken got %0b want %0b", upd_taken, e.ut); end
    n_cmp++; if (flush !== e.fl) begin n_bad++; $display("[TB] FAIL correct.flush got %0b want %0b", flush, e.fl); end
    n_cmp++; if (branch_cnt !== e.bc) begin n_bad++; $display("[TB] FAIL correct.branch_cnt got %h want %h", branch_cnt, e.bc); end
    n_cmp++; if (empty !== e.em) begin n_bad++; $display("[TB] FAIL correct.empty got %0b want %0b", empty, e.em); end
    idle();
    e = exp_q.pop_front();
    n_cmp++; if (upd_valid !== e.uv) begin n_bad++; $display("[TB] FAIL correct.upd_pulse_width got %0b want %0b", upd_valid, e.uv); end
  endtask

  task automatic test_mispredict();
    exp_t e;
    cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0);
    void'(exp_q.pop_front());
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD0000);
    e = exp_q.pop_front();
    n_cmp++; if (flush !== e.fl) begin n_bad++; $display("[TB] FAIL mispred.flush got %0b want %0b", flush, e.fl); end
    n_cmp++; if (redirect_pc !== e.rp) begin n_bad++; $display("[TB] FAIL mispred.redirect_pc got %h want %h", redirect_pc, e.rp); end
    n_cmp++; if (mispred_cnt !== e.mc) begin n_bad++; $display("[TB] FAIL mispred.mispred_cnt got %h want %h", mispred_cnt, e.mc); end
    n_cmp++; if (upd_taken !== e.ut) begin n_bad++; $display("[TB] FAIL mispred.upd_taken got %0b want %0b", upd_taken, e.ut); end
    idle();
    e = exp_q.pop_front();
    n_cmp++; if (flush !== e.fl) begin n_bad++; $display("[TB] FAIL mispred.flush_one_cycle got %0b want %0b", flush, e.fl); end
  endtask

  task automatic test_flush_clears();
    exp_t e;
    cycle(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0); void'(exp_q.pop_front());
    cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0); void'(exp_q.pop_front());
    cycle(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'h0); void'(exp_q.pop_front());
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80);
    e = exp_q.pop_front();
    n_cmp++; if (redirect_pc !== e.rp) begin n_bad++; $display("[TB] FAIL flushq.redirect_pc got %h want %h", redirect_pc, e.rp); end
    n_cmp++; if (upd_addr !== e.ua) begin n_bad++; $display("[TB] FAIL flushq.upd_addr got %h want %h", upd_addr, e.ua); end
    n_cmp++; if (empty !== e.em) begin n_bad++; $display("[TB] FAIL flushq.empty got %0b want %0b", empty, e.em); end
    n_cmp++; if (f_ready !== e.fr) begin n_bad++; $display("[TB] FAIL flushq.f_ready_in_flush got %0b want %0b", f_ready, e.fr); end
    // Push and resolve attempted during the flush cycle: both must be ignored.
    cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (empty !== e.em) begin n_bad++; $display("[TB] FAIL flushq.push_refused got empty=%0b want %0b", empty, e.em); end
    n_cmp++; if (upd_valid !== e.uv) begin n_bad++; $display("[TB] FAIL flushq.no_update got %0b want %0b", upd_valid, e.uv); end
    // Resolve against an empty queue.
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (upd_valid !== e.uv) begin n_bad++; $display("[TB] FAIL empty_resolve.upd_valid got %0b want %0b", upd_valid, e.uv); end
    n_cmp++; if (branch_cnt !== e.bc) begin n_bad++; $display("[TB] FAIL empty_resolve.branch_cnt got %h want %h", branch_cnt, e.bc); end
    n_cmp++; if (mispred_cnt !== e.mc) begin n_bad++; $display("[TB] FAIL empty_resolve.mispred_cnt got %h want %h", mispred_cnt, e.mc); end
    cycle(1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (empty !== e.em) begin n_bad++; $display("[TB] FAIL flushq.push_after got empty=%0b want %0b", empty, e.em); end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (upd_addr !== e.ua) begin n_bad++; $display("[TB] FAIL flushq.next_head got %h want %h", upd_addr, e.ua); end
  endtask

  task automatic test_full();
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 32'h1000 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0);
      void'(exp_q.pop_front());
    end
    n_cmp++; if (f_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL full.f_ready got %0b want 0", f_ready); end
    cycle(1'b1, 32'h2000, 1'b1, 1'b1, 1'b1, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (f_ready !== e.fr) begin n_bad++; $display("[TB] FAIL full.f_ready_after got %0b want %0b", f_ready, e.fr); end
    n_cmp++; if (upd_addr !== e.ua) begin n_bad++; $display("[TB] FAIL full.order0 got %h want %h", upd_addr, e.ua); end
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
      e = exp_q.pop_front();
      n_cmp++; if (upd_valid !== e.uv || upd_addr !== e.ua) begin n_bad++; $display("[TB] FAIL full.order%0d got v=%0b a=%h want v=%0b a=%h", i, upd_valid, upd_addr, e.uv, e.ua); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("[TB] FAIL full.refused_not_stored got empty=%0b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    cycle(1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, 32'h0);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 32'h3000 + 32'(i * 8), 1'b0, 1'b1, 1'b0, 32'h0);
      e = exp_q.pop_front();
      n_cmp++; if (upd_valid !== e.uv || upd_addr !== e.ua || upd_taken !== e.ut) begin n_bad++; $display("[TB] FAIL b2b.%0d got v=%0b a=%h t=%0b want v=%0b a=%h t=%0b", i, upd_valid, upd_addr, upd_taken, e.uv, e.ua, e.ut); end
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    e = exp_q.pop_front();
    n_cmp++; if (empty !== e.em || branch_cnt !== e.bc) begin n_bad++; $display("[TB] FAIL b2b.drain got em=%0b bc=%h want em=%0b bc=%h", empty, branch_cnt, e.em, e.bc); end
  endtask

  task automatic test_wrap();
    exp_t e;
    cycle(1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 32'h0);
    void'(exp_q.pop_front());
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h12345678);
    e = exp_q.pop_front();
    n_cmp++; if (flush !== e.fl || redirect_pc !== e.rp) begin n_bad++; $display("[TB] FAIL wrap.redirect got fl=%0b pc=%h want fl=%0b pc=%h", flush, redirect_pc, e.fl, e.rp); end
    idle();
    void'(exp_q.pop_front());
  endtask

  task automatic test_saturation();
    exp_t e;
    int   guard;
    guard = 0;
    while (m_bc != 16'hFFFF && guard < 70000) begin
      cycle(1'b1, 32'h4000, 1'b1, 1'b1, 1'b1, 32'h0);
      void'(exp_q.pop_front());
      guard++;
    end
    n_cmp++; if (branch_cnt !== 16'hFFFF) begin n_bad++; $display("[TB] FAIL sat.reach got %h want ffff", branch_cnt); end
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 32'h4000, 1'b1, 1'b1, 1'b1, 32'h0);
      e = exp_q.pop_front();
      n_cmp++; if (branch_cnt !== e.bc || upd_valid !== e.uv) begin n_bad++; $display("[TB] FAIL sat.hold%0d got bc=%h v=%0b want bc=%h v=%0b", i, branch_cnt, upd_valid, e.bc, e.uv); end
    end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h5000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0);
      void'(exp_q.pop_front());
    end
    test_reset("rst_inflight");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h6000 + 32'(i * 4), 1'b0, 1'b0, 1'b0, 32'h0);
      void'(exp_q.pop_front());
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h7000);
    void'(exp_q.pop_front());
    n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_flush.precondition got flush=%0b want 1", flush); end
    test_reset("rst_flush");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    f_valid = 1'b0; f_pc = 32'h0; f_predict = 1'b0;
    r_valid = 1'b0; r_taken = 1'b0; r_target = 32'h0;
    m_flush = 1'b0; m_bc = 16'h0; m_mc = 16'h0;
    @(posedge clk);
    #1;
    test_reset("reset");
    test_correct_predict();
    test_mispredict();
    test_flush_clears();
    test_full();
    test_back_to_back();
    test_wrap();
    test_saturation();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
